// File: rtl/video_timing_pkg.sv
// Shared 640x480@60 timing defaults, RGB444 pixel layout and sync polarity constants
// for the pixel-domain raster generator.
package video_timing_pkg;

   localparam int H_ACTIVE_640 = 640;
   localparam int H_FP_640     = 16;
   localparam int H_SYNC_640   = 96;
   localparam int H_BP_640     = 48;
   localparam int V_ACTIVE_480 = 480;
   localparam int V_FP_480     = 10;
   localparam int V_SYNC_480   = 2;
   localparam int V_BP_480     = 33;

   localparam logic POL_LOW  = 1'b0;
   localparam logic POL_HIGH = 1'b1;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   localparam int R_MSB = 11;
   localparam int R_LSB = 8;
   localparam int G_MSB = 7;
   localparam int G_LSB = 4;
   localparam int B_MSB = 3;
   localparam int B_LSB = 0;

   localparam rgb444_t RGB_BLACK = 12'h000;

endpackage

// File: rtl/video_raster_counter.sv
// Horizontal/vertical raster counters with active, sync-window and vblank decodes;
// resolution is set purely by parameters so other modes can reuse it.
module video_raster_counter
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_640,
   parameter int H_FP     = H_FP_640,
   parameter int H_SYNC   = H_SYNC_640,
   parameter int H_BP     = H_BP_640,
   parameter int V_ACTIVE = V_ACTIVE_480,
   parameter int V_FP     = V_FP_480,
   parameter int V_SYNC   = V_SYNC_480,
   parameter int V_BP     = V_BP_480
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic active,
   output logic hsync_win,
   output logic vsync_win,
   output logic vblank_hit
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_ZERO    = {HW{1'b0}};
   localparam logic [HW-1:0] H_ONE     = HW'(1'b1);
   localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEGIN  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);

   localparam logic [VW-1:0] V_ZERO    = {VW{1'b0}};
   localparam logic [VW-1:0] V_ONE     = VW'(1'b1);
   localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEGIN  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0] h_cnt_r;
   logic [VW-1:0] v_cnt_r;

   // Raster position; held at the frame origin while not running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_r <= H_ZERO;
         v_cnt_r <= V_ZERO;
      end else if (!run) begin
         h_cnt_r <= H_ZERO;
         v_cnt_r <= V_ZERO;
      end else if (h_cnt_r == H_LAST) begin
         h_cnt_r <= H_ZERO;
         v_cnt_r <= (v_cnt_r == V_LAST) ? V_ZERO : v_cnt_r + V_ONE;
      end else begin
         h_cnt_r <= h_cnt_r + H_ONE;
      end
   end

   assign active     = (h_cnt_r < H_ACT_END) && (v_cnt_r < V_ACT_END);
   assign hsync_win  = (h_cnt_r >= HS_BEGIN) && (h_cnt_r < HS_END);
   assign vsync_win  = (v_cnt_r >= VS_BEGIN) && (v_cnt_r < VS_END);
   assign vblank_hit = (h_cnt_r == H_ZERO) && (v_cnt_r == V_ACT_END);

endmodule

// File: rtl/video_timing_gen.sv
// Raster generator and pixel sequencer: pulls RGB444 pixels over valid/ready during
// the active area and drives registered sync/blank/colour outputs one cycle later.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int   H_ACTIVE  = H_ACTIVE_640,
   parameter int   H_FP      = H_FP_640,
   parameter int   H_SYNC    = H_SYNC_640,
   parameter int   H_BP      = H_BP_640,
   parameter int   V_ACTIVE  = V_ACTIVE_480,
   parameter int   V_FP      = V_FP_480,
   parameter int   V_SYNC    = V_SYNC_480,
   parameter int   V_BP      = V_BP_480,
   parameter logic HSYNC_POL = POL_LOW,
   parameter logic VSYNC_POL = POL_LOW
) (
   input  logic        clk_pixel,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [11:0] pix_data,
   input  logic        pix_valid,
   output logic        pix_ready,
   output logic        vblank_start,
   output logic        underflow,
   input  logic        underflow_clr,
   output logic        vga_hsync,
   output logic        vga_vsync,
   output logic        vga_blank,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b
);

   logic    active;
   logic    hsync_win;
   logic    vsync_win;
   logic    vblank_hit;
   logic    xfer;
   logic    starve;
   rgb444_t pix_in;

   video_raster_counter #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_raster (
      .clk        (clk_pixel),
      .rst_n      (reset_n),
      .run        (enable),
      .active     (active),
      .hsync_win  (hsync_win),
      .vsync_win  (vsync_win),
      .vblank_hit (vblank_hit)
   );

   // Ready is gated by reset_n so nothing is consumed while the counters are forced.
   assign pix_in    = rgb444_t'(pix_data);
   assign pix_ready = reset_n & enable & active;
   assign xfer      = pix_ready & pix_valid;
   assign starve    = pix_ready & ~pix_valid;

   // Registered video bundle, one cycle behind the raster position.
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         vga_blank    <= 1'b1;
         vga_hsync    <= ~HSYNC_POL;
         vga_vsync    <= ~VSYNC_POL;
         vblank_start <= 1'b0;
         vga_r        <= RGB_BLACK.r;
         vga_g        <= RGB_BLACK.g;
         vga_b        <= RGB_BLACK.b;
      end else if (!enable) begin
         vga_blank    <= 1'b1;
         vga_hsync    <= ~HSYNC_POL;
         vga_vsync    <= ~VSYNC_POL;
         vblank_start <= 1'b0;
         vga_r        <= RGB_BLACK.r;
         vga_g        <= RGB_BLACK.g;
         vga_b        <= RGB_BLACK.b;
      end else begin
         vga_blank    <= ~active;
         vga_hsync    <= hsync_win ? HSYNC_POL : ~HSYNC_POL;
         vga_vsync    <= vsync_win ? VSYNC_POL : ~VSYNC_POL;
         vblank_start <= vblank_hit;
         vga_r        <= xfer ? pix_in.r : RGB_BLACK.r;
         vga_g        <= xfer ? pix_in.g : RGB_BLACK.g;
         vga_b        <= xfer ? pix_in.b : RGB_BLACK.b;
      end
   end

   // Sticky underflow; a new starve event outranks a simultaneous clear.
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         underflow <= 1'b0;
      end else if (starve) begin
         underflow <= 1'b1;
      end else if (underflow_clr) begin
         underflow <= 1'b0;
      end else begin
         underflow <= underflow;
      end
   end

endmodule
